qr_matrix_feeder: RTL and testbench

//  Transmit side of the QR array input stream. Buffers 8x4 matrices that arrive row-by-row from the

---
 rtl/qr_matrix_feeder.sv | 155 +++++++++++++++
 tb/tb_qr_matrix_feeder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/qr_matrix_feeder.sv
// Ping-pong matrix buffer that replays 8-row matrices as gapless frames into the QR array.
// The host fills one bank while the other bank streams out.
module qr_matrix_feeder #(
    parameter int DATA_W = 17,
    parameter int ROWS   = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [4*DATA_W-1:0]   s_data,
    output logic                  qr_valid,
    output logic [DATA_W-1:0]     qr_in_1,
    output logic [DATA_W-1:0]     qr_in_2,
    output logic [DATA_W-1:0]     qr_in_3,
    output logic [DATA_W-1:0]     qr_in_4,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [4*DATA_W-1:0] r_mem [2][ROWS];
    logic [1:0]          r_full;
    logic                r_wr_bank;
    logic [RW-1:0]       r_wr_row;
    logic                r_rd_bank;
    logic [RW-1:0]       r_out_row;

    logic                r_qr_valid;
    logic [4*DATA_W-1:0] r_qr_data;
    logic                r_frame_start;
    logic                r_frame_done;
    logic [CNT_W-1:0]    r_frame_cnt;

    logic                w_accept;
    logic [1:0]          w_set;
    logic [1:0]          w_clr;
    logic                w_load;
    logic                w_load_bank;
    logic [RW-1:0]       w_load_row;
    logic                w_release;

    // Readiness depends only on registered flags, so s_valid never loops back into s_ready.
    assign s_ready  = !r_full[r_wr_bank];
    assign w_accept = s_valid && s_ready;
    assign w_set    = (w_accept && (r_wr_row == LAST_ROW)) ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr    = w_release ? (2'b01 << r_rd_bank) : 2'b00;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_bank][r_wr_row] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_wr_row  <= '0;
            r_full    <= 2'b00;
        end else begin
            r_full <= (r_full | w_set) & ~w_clr;
            if (w_accept) begin
                if (r_wr_row == LAST_ROW) begin
                    r_wr_row  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_row <= r_wr_row + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // On the last row the other bank, if already full, is chained in without a bubble.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_bank  = r_rd_bank;
        w_load_row   = '0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_load       = 1'b1;
                    w_next_state = STREAM;
                end
            end
            STREAM: begin
                if (r_out_row == LAST_ROW) begin
                    w_release = 1'b1;
                    if (r_full[~r_rd_bank]) begin
                        w_load      = 1'b1;
                        w_load_bank = ~r_rd_bank;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else begin
                    w_load     = 1'b1;
                    w_load_row = r_out_row + RW'(1);
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_bank     <= 1'b0;
            r_out_row     <= '0;
            r_qr_valid    <= 1'b0;
            r_qr_data     <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_rd_bank     <= r_rd_bank ^ w_release;
            r_qr_valid    <= w_load;
            r_qr_data     <= w_load ? r_mem[w_load_bank][w_load_row] : '0;
            r_frame_start <= w_load && (w_load_row == '0);
            r_frame_done  <= w_load && (w_load_row == LAST_ROW);
            if (w_load) begin
                r_out_row <= w_load_row;
            end
            if (w_release) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

    assign qr_valid    = r_qr_valid;
    assign qr_in_1     = r_qr_data[DATA_W-1:0];
    assign qr_in_2     = r_qr_data[2*DATA_W-1:DATA_W];
    assign qr_in_3     = r_qr_data[3*DATA_W-1:2*DATA_W];
    assign qr_in_4     = r_qr_data[4*DATA_W-1:3*DATA_W];
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_qr_matrix_feeder.sv
// Directed bench for qr_matrix_feeder: a negedge monitor scores every emitted row against
// the rows the bench itself sent, and tracks bank occupancy to predict s_ready.
module tb_qr_matrix_feeder;

    localparam int DATA_W = 17;
    localparam int ROWS   = 8;
    localparam int CNT_W  = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [4*DATA_W-1:0] s_data = '0;
    logic                qr_valid;
    logic [DATA_W-1:0]   qr_in_1, qr_in_2, qr_in_3, qr_in_4;
    logic                frame_start, frame_done;
    logic [CNT_W-1:0]    frame_cnt;

    int checkCount = 0;
    int errorCount = 0;

    logic [4*DATA_W-1:0] expQ[$];
    int acceptedRows   = 0;
    int releasedFrames = 0;
    int rowIdx         = 0;
    int runLen         = 0;
    int lastRun        = 0;
    logic prevValid    = 1'b0;

    qr_matrix_feeder #(.DATA_W(DATA_W), .ROWS(ROWS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .qr_valid(qr_valid), .qr_in_1(qr_in_1), .qr_in_2(qr_in_2), .qr_in_3(qr_in_3),
        .qr_in_4(qr_in_4), .frame_start(frame_start), .frame_done(frame_done),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [4*DATA_W-1:0] makeRow(input int i);
        return {DATA_W'(4*i+4), DATA_W'(4*i+3), DATA_W'(4*i+2), DATA_W'(4*i+1)};
    endfunction

    // Scoreboard: output check first, then register the beat the coming posedge will accept.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            acceptedRows   = 0;
            releasedFrames = 0;
            rowIdx         = 0;
            runLen         = 0;
            prevValid      = 1'b0;
        end else begin
            checkOutput("s_ready", 128'(s_ready), 128'((acceptedRows / ROWS - releasedFrames) < 2));
            if (qr_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_row", 128'(1), 128'(0));
                end else begin
                    checkOutput("row_data", 128'({qr_in_4, qr_in_3, qr_in_2, qr_in_1}),
                                128'(expQ.pop_front()));
                end
                checkOutput("frame_flags", 128'({frame_start, frame_done}),
                            128'({rowIdx == 0, rowIdx == ROWS-1}));
                if (rowIdx == ROWS-1) begin
                    releasedFrames++;
                    rowIdx = 0;
                end else begin
                    rowIdx++;
                end
                runLen++;
            end else begin
                checkOutput("idle_zero",
                            128'({qr_in_4, qr_in_3, qr_in_2, qr_in_1, frame_start, frame_done}),
                            128'(0));
                if (prevValid) begin
                    checkOutput("gap_at_boundary", 128'(rowIdx), 128'(0));
                    lastRun = runLen;
                end
                runLen = 0;
            end
            prevValid = qr_valid;
            if (s_valid && s_ready) begin
                expQ.push_back(s_data);
                acceptedRows++;
            end
        end
    end

    // Offers one row from posedge+1 and returns at posedge+1 just after it is accepted.
    task automatic applyStimulus(input logic [4*DATA_W-1:0] row);
        logic acc;
        acc     = 1'b0;
        s_valid = 1'b1;
        s_data  = row;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        s_valid = 1'b0;
        if (!acc) checkOutput("accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic idleCycles(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            if (expQ.size() == 0 && !qr_valid) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("drain", 128'(done), 128'(1));
        idleCycles(2);
    endtask

    task automatic waitFrameStart();
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (frame_start) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("frame_start_seen", 128'(seen), 128'(1));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seq;
        seq = 0;

        // Reset state
        #12;
        checkOutput("rst_valid", 128'(qr_valid), 128'(0));
        checkOutput("rst_data", 128'({qr_in_4, qr_in_3, qr_in_2, qr_in_1}), 128'(0));
        checkOutput("rst_cnt", 128'(frame_cnt), 128'(0));
        checkOutput("rst_ready", 128'(s_ready), 128'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        idleCycles(2);

        // Single frame with latency check
        for (int i = 0; i < ROWS; i++) applyStimulus(makeRow(seq++));
        checkOutput("latency_before", 128'(qr_valid), 128'(0));
        @(posedge clk);
        #1;
        checkOutput("latency_valid", 128'(qr_valid), 128'(1));
        checkOutput("first_in_1", 128'(qr_in_1), 128'(1));
        checkOutput("first_start", 128'(frame_start), 128'(1));
        waitDrain();
        checkOutput("cnt_one", 128'(frame_cnt), 128'(1));

        // Reset pulse while idle
        #2 rst = 1'b1;
        #1;
        checkOutput("idle_rst_cnt", 128'(frame_cnt), 128'(0));
        checkOutput("idle_rst_ready", 128'(s_ready), 128'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        idleCycles(2);

        // Two matrices back-to-back must stream as one unbroken 16-row run
        for (int i = 0; i < 2*ROWS; i++) applyStimulus(makeRow(seq++));
        waitDrain();
        checkOutput("run_len_16", 128'(lastRun), 128'(2*ROWS));
        checkOutput("cnt_two", 128'(frame_cnt), 128'(2));

        // 40 rows with random host gaps
        for (int i = 0; i < 5*ROWS; i++) begin
            applyStimulus(makeRow(seq++));
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
        end
        waitDrain();
        checkOutput("cnt_seven", 128'(frame_cnt), 128'(7));

        // Reset while row 3 is on the outputs
        for (int i = 0; i < ROWS; i++) applyStimulus(makeRow(seq++));
        waitFrameStart();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midframe_valid", 128'(qr_valid), 128'(0));
        checkOutput("midframe_cnt", 128'(frame_cnt), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        idleCycles(2);
        for (int i = 0; i < ROWS; i++) applyStimulus(makeRow(100 + i));
        waitFrameStart();
        checkOutput("fresh_row0", 128'(qr_in_1), 128'(401));
        waitDrain();
        checkOutput("fresh_cnt", 128'(frame_cnt), 128'(1));

        // Signed extremes pass bit-exact
        applyStimulus({DATA_W'(0), DATA_W'(-1), DATA_W'(65535), DATA_W'(-65536)});
        for (int i = 1; i < ROWS; i++) applyStimulus(makeRow(seq++));
        waitFrameStart();
        checkOutput("ext_in_1", 128'(qr_in_1), 128'(17'h10000));
        checkOutput("ext_in_2", 128'(qr_in_2), 128'(17'h0FFFF));
        checkOutput("ext_in_3", 128'(qr_in_3), 128'(17'h1FFFF));
        checkOutput("ext_in_4", 128'(qr_in_4), 128'(17'h00000));
        waitDrain();
        checkOutput("ext_cnt", 128'(frame_cnt), 128'(2));
        checkOutput("queue_empty", 128'(expQ.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
